// File: rtl/mod_parity_ram.sv
`default_nettype none
// ============================================================================
// Module   : mod_parity_ram
// Purpose  : Single-port RAM with one parity bit per word. On reset it clears
//            itself one word per cycle. Reads return data one cycle later and
//            flag a parity mismatch. Error status is kept as a sticky flag,
//            the first failing address and a saturating error count.
// Revision : 1.0 - initial release
// ============================================================================
module mod_parity_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              ren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              inj_err,
  input  logic              clr_err,
  output logic [DATA_W-1:0] r_data,
  output logic              rd_valid,
  output logic              err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy
);

  // The storage index only needs enough bits to cover DEPTH entries.
  localparam int                c_idx_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

  localparam logic [0:0] c_st_init = 1'b0;
  localparam logic [0:0] c_st_idle = 1'b1;

  // Each word holds {parity, data}.
  logic [DATA_W:0]        r_mem [DEPTH];
  logic [0:0]             r_state;
  logic [c_idx_w-1:0]     r_init_idx;
  logic [DATA_W-1:0]      r_data_q;
  logic                   r_rd_valid;
  logic                   r_err;
  logic                   r_err_sticky;
  logic [ADDR_W-1:0]      r_err_addr;
  logic [CNT_W-1:0]       r_err_cnt;

  logic                   w_idle;
  logic                   w_addr_ok;
  logic [c_idx_w-1:0]     w_addr_idx;
  logic [DATA_W:0]        w_rd_word;
  logic                   w_rd;
  logic                   w_err_evt;
  logic                   w_mem_we;
  logic [c_idx_w-1:0]     w_mem_idx;
  logic [DATA_W:0]        w_mem_wdata;
  logic                   w_sticky_base;
  logic [CNT_W-1:0]       w_cnt_base;
  logic [ADDR_W-1:0]      w_eaddr_base;

  assign w_idle     = (r_state == c_st_idle);
  assign w_addr_ok  = ({1'b0, addr} < c_depth);
  assign w_addr_idx = addr[c_idx_w-1:0];
  assign w_rd       = w_idle && ren;

  // Out-of-range reads see an all-zero word, which also has consistent parity.
  always_comb begin
    w_rd_word = '0;
    if (w_addr_ok) begin
      w_rd_word = r_mem[w_addr_idx];
    end
  end

  assign w_err_evt = w_rd && w_addr_ok &&
                     ((^w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W]);

  // Storage write port: the init sweep owns it while busy, the user afterwards.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = r_init_idx;
    w_mem_wdata = '0;
    if (!w_idle) begin
      w_mem_we = 1'b1;
    end else if (wen && w_addr_ok) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = w_addr_idx;
      w_mem_wdata = {(^w_data) ^ inj_err, w_data};
    end
  end

  // Storage array has no reset; the init sweep clears it after every reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // Init sweep: walk every index once, then hand the RAM to the user.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_init;
      r_init_idx <= '0;
    end else if (r_state == c_st_init) begin
      if (r_init_idx == c_last_idx) begin
        r_state    <= c_st_idle;
        r_init_idx <= '0;
      end else begin
        r_init_idx <= r_init_idx + 1'b1;
      end
    end
  end

  // Read pipeline: data is captured before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q   <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      r_err      <= w_err_evt;
      if (w_rd) begin
        r_data_q <= w_rd_word[DATA_W-1:0];
      end
    end
  end

  // A clear and an error on the same edge behave as "clear, then record".
  always_comb begin
    w_sticky_base = r_err_sticky;
    w_cnt_base    = r_err_cnt;
    w_eaddr_base  = r_err_addr;
    if (w_idle && clr_err) begin
      w_sticky_base = 1'b0;
      w_cnt_base    = '0;
      w_eaddr_base  = '0;
    end
  end

  // Error status: sticky flag, first failing address, saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
      r_err_cnt    <= '0;
    end else if (w_err_evt) begin
      r_err_sticky <= 1'b1;
      r_err_addr   <= w_sticky_base ? w_eaddr_base : addr;
      r_err_cnt    <= (w_cnt_base == c_cnt_max) ? c_cnt_max : w_cnt_base + 1'b1;
    end else begin
      r_err_sticky <= w_sticky_base;
      r_err_addr   <= w_eaddr_base;
      r_err_cnt    <= w_cnt_base;
    end
  end

  assign r_data     = r_data_q;
  assign rd_valid   = r_rd_valid;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign err_addr   = r_err_addr;
  assign err_cnt    = r_err_cnt;
  assign busy       = (r_state == c_st_init);

endmodule
`default_nettype wire

// File: tb/tb_mod_parity_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_parity_ram
// Purpose  : Randomised and directed stimulus for mod_parity_ram, with an
//            abstract memory model and a queue-based read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_parity_ram;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wen = 1'b0;
  logic              ren = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              inj_err = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] r_data;
  logic              rd_valid;
  logic              err;
  logic              err_sticky;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  err_cnt;
  logic              busy;

  mod_parity_ram #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .addr(addr),
    .w_data(w_data), .inj_err(inj_err), .clr_err(clr_err),
    .r_data(r_data), .rd_valid(rd_valid), .err(err),
    .err_sticky(err_sticky), .err_addr(err_addr), .err_cnt(err_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              e;
    logic              s;
    logic [CNT_W-1:0]  c;
    logic [ADDR_W-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // Reference model: plain contents plus a "parity is corrupt" mark per word.
  int   m_data [DEPTH];
  bit   m_bad  [DEPTH];
  bit   m_sticky;
  int   m_cnt;
  int   m_eaddr;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = 0;
      m_bad[i]  = 0;
    end
    m_sticky = 0;
    m_cnt    = 0;
    m_eaddr  = 0;
  endtask

  // One user cycle: drive inputs, predict the result and queue it for the monitor.
  task automatic cyc(input bit w, input bit r, input int a, input int d,
                     input bit inj, input bit clr);
    exp_t x;
    bit   in_rng;
    bit   e;
    @(negedge clk);
    wen = w; ren = r; addr = ADDR_W'(a); w_data = DATA_W'(d);
    inj_err = inj; clr_err = clr;
    in_rng = (a < DEPTH);
    e = r && in_rng && m_bad[a];
    if (clr) begin
      m_sticky = 0; m_cnt = 0; m_eaddr = 0;
    end
    if (e) begin
      if (!m_sticky) m_eaddr = a;
      m_sticky = 1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    if (r) begin
      x.d = in_rng ? DATA_W'(m_data[a]) : '0;
      x.e = e;
      x.s = m_sticky;
      x.c = CNT_W'(m_cnt);
      x.a = ADDR_W'(m_eaddr);
      exp_q.push_back(x);
    end
    if (w && in_rng) begin
      m_data[a] = d & ((1 << DATA_W) - 1);
      m_bad[a]  = inj;
    end
  endtask

  task automatic idle_in();
    wen = 0; ren = 0; addr = '0; w_data = '0; inj_err = 0; clr_err = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r_data"}, r_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_sticky"}, err_sticky, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Release reset and count edges until busy drops; inputs toggle meanwhile
  // and must have no effect.
  task automatic release_and_init();
    int n;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    n = 0;
    while (n < 100) begin
      wen = 1; ren = 1; clr_err = 1; inj_err = 1;
      addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      w_data = DATA_W'($urandom);
      @(posedge clk);
      #1;
      n++;
      if (!busy) break;
    end
    chk("busy_cycles", n, DEPTH);
    idle_in();
  endtask

  // Monitor: every cycle a queued read must appear, and nothing else may.
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("rd_valid", rd_valid, 1);
        chk("r_data", r_data, x.d);
        chk("err", err, x.e);
        chk("err_sticky", err_sticky, x.s);
        chk("err_cnt", err_cnt, x.c);
        chk("err_addr", err_addr, x.a);
      end else begin
        chk("rd_valid_idle", rd_valid, 0);
        chk("err_idle", err, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk_reset_outputs("por");
    release_and_init();

    // Fresh RAM reads back as zero with no errors.
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Write i*3 everywhere, then read back with gaps between reads.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, i, i * 3, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, i, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end

    // Two injected errors: first address is held, count reaches 2.
    cyc(1, 0, 5, 8'hA5, 1, 0);
    cyc(0, 1, 5, 0, 0, 0);
    cyc(1, 0, 7, 8'h3C, 1, 0);
    cyc(0, 1, 7, 0, 0, 0);

    // Saturation, then a clear landing on the same edge as a new error.
    for (int i = 0; i < 20; i++) cyc(0, 1, 5, 0, 0, 0);
    cyc(0, 1, 7, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);

    // Read-before-write on the same address.
    cyc(1, 0, 3, 8'h11, 0, 0);
    cyc(1, 1, 3, 8'h22, 0, 0);
    cyc(0, 1, 3, 0, 0, 0);

    // Out-of-range write is dropped; out-of-range read gives zero, no error.
    cyc(1, 0, DEPTH + 2, 8'hFF, 1, 0);
    cyc(0, 1, DEPTH + 2, 0, 0, 0);
    cyc(0, 1, DEPTH + 2 - DEPTH, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, DEPTH + 3), $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Reset in the middle of the init sweep (at index 8).
    @(negedge clk);
    rst_n = 0;
    idle_in();
    @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (8) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk_reset_outputs("mid_init");
    release_and_init();

    // Reset while a read is pending: the read must never complete.
    cyc(1, 0, 9, 8'h5A, 0, 0);
    @(negedge clk);
    ren = 1; addr = ADDR_W'(9);
    #2;
    rst_n = 0;
    #1;
    chk_reset_outputs("mid_read");
    @(posedge clk);
    #1;
    chk("mid_read_rd_valid_after_edge", rd_valid, 0);
    idle_in();
    release_and_init();
    cyc(0, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    chk("queue_drained", exp_q.size(), 0);
    done = 1;
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_parity_ram.md
MOD_PARITY_RAM -- requirements
Module: mod_parity_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of words, with DEPTH <= 2**ADDR_W.
REQ-003 The block SHALL have parameter ADDR_W, default 4, address width.
REQ-004 The block SHALL have parameter CNT_W, default 4, error counter width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-006 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 The block SHALL have port wen, input, 1, write enable.
REQ-008 The block SHALL have port ren, input, 1, read enable.
REQ-009 The block SHALL have port addr, input, ADDR_W, shared read/write address.
REQ-010 The block SHALL have port w_data, input, DATA_W, write data.
REQ-011 The block SHALL have port inj_err, input, 1, which inverts the stored parity bit on a write.
REQ-012 The block SHALL have port clr_err, input, 1, which clears the error status.
REQ-013 The block SHALL have port r_data, output, DATA_W, registered read data.
REQ-014 The block SHALL have port rd_valid, output, 1, read data valid pulse.
REQ-015 The block SHALL have port err, output, 1, parity error pulse, aligned with rd_valid.
REQ-016 The block SHALL have port err_sticky, output, 1, latched error flag.
REQ-017 The block SHALL have port err_addr, output, ADDR_W, address of the first error since the last clear.
REQ-018 The block SHALL have port err_cnt, output, CNT_W, saturating parity error count.
REQ-019 The block SHALL have port busy, output, 1, high while initialisation runs.

Function
REQ-020 The block SHALL store DEPTH entries of DATA_W+1 bits: data plus parity, where parity = XOR-reduce(data).
REQ-021 The FSM SHALL have two states: INIT and IDLE; INIT SHALL be entered on reset.
REQ-022 In INIT, one entry per cycle, starting at index 0, SHALL be written with data 0 and parity 0; after index DEPTH-1 is written the FSM SHALL go to IDLE, so INIT lasts exactly DEPTH cycles.
REQ-023 busy SHALL be 1 in INIT and 0 in IDLE; wen, ren, inj_err and clr_err SHALL be ignored while busy=1.
REQ-024 In IDLE with wen=1 and addr<DEPTH, the entry SHALL be written with w_data and parity XOR inj_err.
REQ-025 In IDLE with ren=1, at the next edge r_data SHALL take the stored data, and rd_valid SHALL be 1 for exactly one cycle; the read latency is 1 cycle.
REQ-026 err SHALL be 1 in the rd_valid cycle if and only if XOR-reduce(stored data) differs from the stored parity.
REQ-027 When ren is 0, r_data SHALL hold its last value.
REQ-028 When wen and ren are both 1 to the same address, the read SHALL return the old contents (read-before-write), and the write SHALL complete.
REQ-029 With addr>=DEPTH, a write SHALL be discarded; a read SHALL give r_data=0, rd_valid=1 and err=0.
REQ-030 On err, err_sticky SHALL be set, and err_cnt SHALL increment, saturating at 2**CNT_W-1 with no wrap-around.
REQ-031 err_addr SHALL capture the read address only when err occurs while err_sticky=0.
REQ-032 clr_err SHALL clear err_sticky, err_cnt and err_addr to 0 at the next edge.
REQ-033 When clr_err and an error event occur in the same edge, the clear SHALL apply first, giving err_sticky=1, err_cnt=1 and err_addr=the new address.

Reset
REQ-034 When rst_n=0, asynchronously: r_data=0, rd_valid=0, err=0, err_sticky=0, err_addr=0, err_cnt=0, busy=1, FSM=INIT, init index=0.
REQ-035 Reset asserted mid-INIT or mid-read SHALL abort the operation; initialisation SHALL restart from index 0 after rst_n rises, and any in-flight rd_valid SHALL be lost.

Verification
REQ-036 Release reset, count busy cycles, then read all addresses -> busy high exactly 16 cycles, every r_data=0, err never 1.
REQ-037 Write addr i with data i*3 for i=0..15, then read each -> r_data=i*3 one cycle after ren, rd_valid a single-cycle pulse, err=0.
REQ-038 Write addr 5 with 0xA5 and inj_err=1, read addr 5, then addr 7 with inj_err=1, read addr 7 -> err pulses on both reads, err_sticky=1, err_addr=5, err_cnt=2.
REQ-039 Repeat an injected-error read 20 times with CNT_W=4 -> err_cnt saturates at 15; clr_err in the same cycle as the next error -> err_cnt=1, err_sticky=1.
REQ-040 Same-cycle wen and ren to addr 3 (old 0x11, new 0x22) -> r_data=0x11; a following read -> 0x22.
REQ-041 Assert rst_n=0 during INIT at index 8 and during a pending read -> all outputs reset immediately, rd_valid never pulses, busy high 16 cycles after release.
